// File: rtl/ex_stage_fwd_mul_if.sv
// ex_stage_fwd_mul_if: ID/EX inputs, forwarding sources and EX/MEM outputs of the execute stage
interface ex_stage_fwd_mul_if;
  logic [1:0]  WB_i;
  logic [1:0]  M_i;
  logic [3:0]  EX_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [31:0] signextend_i;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic [4:0]  rd_i;
  logic        exmem_regwrite_i;
  logic [4:0]  exmem_rd_i;
  logic [31:0] exmem_data_i;
  logic        memwb_regwrite_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_data_i;
  logic [1:0]  WB_o;
  logic [1:0]  M_o;
  logic [31:0] alu_result_o;
  logic [31:0] wdata_o;
  logic [4:0]  wreg_o;
  logic        stall_o;
  modport slave (
    input  WB_i, M_i, EX_i, data1_i, data2_i, signextend_i, rs_i, rt_i, rd_i,
    input  exmem_regwrite_i, exmem_rd_i, exmem_data_i,
    input  memwb_regwrite_i, memwb_rd_i, memwb_data_i,
    output WB_o, M_o, alu_result_o, wdata_o, wreg_o, stall_o
  );
  modport master (
    output WB_i, M_i, EX_i, data1_i, data2_i, signextend_i, rs_i, rt_i, rd_i,
    output exmem_regwrite_i, exmem_rd_i, exmem_data_i,
    output memwb_regwrite_i, memwb_rd_i, memwb_data_i,
    input  WB_o, M_o, alu_result_o, wdata_o, wreg_o, stall_o
  );
endinterface

// File: rtl/ex_stage_fwd_mul.sv
// ex_stage_fwd_mul: execute stage with operand forwarding, ALU, iterative multiplier and EX/MEM register
module ex_stage_fwd_mul #(
  parameter int MUL_ITER = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  ex_stage_fwd_mul_if.slave bus
);
  localparam int CW = $clog2(MUL_ITER);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mcand, mplier, prod;
  logic [31:0]   fwd_a, fwd_b, opb, rtype, alu;
  logic [5:0]    funct;
  logic          is_mul;
  // forwarding (EX/MEM beats MEM/WB, r0 never forwarded) and ALU evaluation
  always_comb begin
    fwd_a = (bus.exmem_regwrite_i && bus.exmem_rd_i != '0 && bus.exmem_rd_i == bus.rs_i) ? bus.exmem_data_i :
            (bus.memwb_regwrite_i && bus.memwb_rd_i != '0 && bus.memwb_rd_i == bus.rs_i) ? bus.memwb_data_i : bus.data1_i;
    fwd_b = (bus.exmem_regwrite_i && bus.exmem_rd_i != '0 && bus.exmem_rd_i == bus.rt_i) ? bus.exmem_data_i :
            (bus.memwb_regwrite_i && bus.memwb_rd_i != '0 && bus.memwb_rd_i == bus.rt_i) ? bus.memwb_data_i : bus.data2_i;
    opb = bus.EX_i[3] ? bus.signextend_i : fwd_b;
    funct = bus.signextend_i[5:0];
    is_mul = bus.EX_i[2:1] == 2'b10 && funct == 6'h18;
    rtype = funct == 6'h20 ? fwd_a + opb :
            funct == 6'h22 ? fwd_a - opb :
            funct == 6'h24 ? fwd_a & opb :
            funct == 6'h25 ? fwd_a | opb : '0;
    alu = state == DONE ? prod :
          bus.EX_i[2:1] == 2'b00 ? fwd_a + opb :
          bus.EX_i[2:1] == 2'b01 ? fwd_a - opb :
          bus.EX_i[2:1] == 2'b10 ? rtype : fwd_a | opb;
  end
  assign bus.stall_o = rst_i && ((state == IDLE && is_mul) || state == BUSY);
  // multiply sequencer: capture operands in IDLE, one shift-add step per BUSY cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (state == IDLE && is_mul) begin
      state  <= BUSY;
      cnt    <= '0;
      mcand  <= fwd_a;
      mplier <= fwd_b;
      prod   <= '0;
    end else if (state == BUSY) begin
      prod   <= prod + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      state  <= cnt == CW'(MUL_ITER - 1) ? DONE : BUSY;
    end else if (state == DONE) begin
      state  <= IDLE;
    end
  end
  // EX/MEM pipeline register; a stall inserts a bubble so MEM keeps draining
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i || bus.stall_o) begin
      bus.WB_o         <= '0;
      bus.M_o          <= '0;
      bus.alu_result_o <= '0;
      bus.wdata_o      <= '0;
      bus.wreg_o       <= '0;
    end else begin
      bus.WB_o         <= bus.WB_i;
      bus.M_o          <= bus.M_i;
      bus.alu_result_o <= alu;
      bus.wdata_o      <= fwd_b;
      bus.wreg_o       <= bus.EX_i[0] ? bus.rd_i : bus.rt_i;
    end
  end
endmodule

// File: doc/ex_stage_fwd_mul.md
Name: ex_stage_fwd_mul

Overview:
- Execute stage of the 5-stage pipeline. It consumes the ID/EX pipeline register outputs (WB/M/EX controls, data1/data2, sign-extended immediate, rs/rt/rd).
- It resolves forwarding from EX/MEM and MEM/WB, performs ALU operations, and runs an iterative shift-add multiplier that stalls the front end.
- It contains the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- MUL_ITER, 32, number of shift-add iterations per multiply. Equals the operand width; fixed data width is 32.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- WB_i  in  2  from ID/EX; [0]=RegWrite, [1]=MemtoReg
- M_i  in  2  from ID/EX; [0]=MemWrite, [1]=MemRead
- EX_i  in  4  from ID/EX; [0]=RegDst, [2:1]=ALUOp, [3]=ALUSrc
- data1_i  in  32  rs read data
- data2_i  in  32  rt read data
- signextend_i  in  32  immediate; [5:0]=funct for R-type
- rs_i, rt_i, rd_i  in  5 each  register numbers
- exmem_regwrite_i  in  1  RegWrite of instruction currently in MEM
- exmem_rd_i  in  5  its destination register
- exmem_data_i  in  32  its ALU result
- memwb_regwrite_i  in  1  RegWrite of instruction currently in WB
- memwb_rd_i  in  5  its destination register
- memwb_data_i  in  32  its write-back data
- WB_o  out  2  EX/MEM registered WB controls
- M_o  out  2  EX/MEM registered M controls
- alu_result_o  out  32  EX/MEM registered result
- wdata_o  out  32  EX/MEM registered forwarded rt value (store data)
- wreg_o  out  5  EX/MEM registered destination (RegDst ? rd : rt)
- stall_o  out  1  combinational; holds PC, IF/ID and ID/EX when high

Behaviour:
- Reset: rst_i low forces all registered outputs to 0 immediately, the FSM to IDLE and the counter to 0. Reset mid-multiply aborts the operation; no result is produced.
- Forwarding for operand A (rs) and B (rt), evaluated separately:
  - Select exmem_data_i if exmem_regwrite_i && exmem_rd_i!=0 && exmem_rd_i==rs/rt.
  - Else select memwb_data_i if the same conditions hold on the memwb_* inputs.
  - Else use data1_i/data2_i.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- ALU second operand: ALUSrc ? signextend_i : forwarded B.
- wdata_o takes forwarded B.
- ALUOp decode:
  - 00 add.
  - 01 sub.
  - 10 R-type by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x18 mul. Other funct values give 0.
  - 11 or.
- Arithmetic is modulo 2^32 with no overflow detection. mul returns the low 32 bits of an unsigned product.
- Non-mul instruction: single-cycle result, latched into EX/MEM on the next rising edge. stall_o=0.
- Multiply FSM (IDLE, BUSY, DONE):
  - IDLE, mul present (ALUOp=10, funct=0x18): stall_o=1. Capture forwarded A and B into the multiplicand/multiplier registers. Clear the product and counter. Go to BUSY.
  - BUSY: stall_o=1. Each cycle, if multiplier[0] then product+=multiplicand. Then multiplicand<<=1, multiplier>>=1, count++. After MUL_ITER iterations go to DONE.
  - DONE: stall_o=0. EX/MEM latches the product with the instruction's WB/M/wreg (ID/EX is still holding them). Return to IDLE.
- Mul latency: stall_o is high for 1+MUL_ITER = 33 consecutive cycles. The result appears on alu_result_o at the edge ending DONE, i.e. 34 edges after the mul enters EX.
- EX/MEM while stall_o=1: latch a bubble (WB_o=0, M_o=0, alu_result_o/wdata_o/wreg_o=0). The upstream instruction in MEM therefore proceeds normally.
- Operands are captured only in the IDLE cycle. Later changes on the forwarding inputs during BUSY have no effect.
- Back-to-back muls: after DONE the next cycle is IDLE; a following mul restarts the full sequence.
- A mul with an operand of 0 still takes the full MUL_ITER iterations; there is no early exit.

Test Plan:
- Reset: assert rst_i low mid-cycle -> all outputs 0 without a clock edge; stall_o=0.
- R-type add, no hazards: data1=5, data2=7, funct 0x20, RegDst=1, rd=3 -> next edge alu_result_o=12, wreg_o=3, WB_o passes through; sub 5-7 -> 0xFFFFFFFE.
- Forwarding priority: rs=4, both EX/MEM and MEM/WB writing r4 (0x11 vs 0x22) -> operand uses 0x11. With exmem_rd=0, rs=0 -> data1_i is used.
- lw/sw immediate path: ALUSrc=1, ALUOp=00, data1=0x100, imm=0xFFFFFFFC, sw with rt forwarded from MEM/WB=0xAB -> alu_result_o=0xFC, wdata_o=0xAB.
- Multiply: data1=6, data2=7 -> stall_o high exactly 33 cycles, EX/MEM bubbles during stall, then alu_result_o=42. 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- Reset during BUSY (cycle 10 of mul) -> outputs 0, stall_o=0. The next add executes normally in 1 cycle.
